// File: rtl/winograd_pkg.sv
// Shared constants and state encoding for the F(2x2,3x3) Winograd input feeder.
package winograd_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int TILE       = 4;
    localparam int KERNEL     = 3;
    localparam int OUT        = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_EMIT,
        ST_DONE
    } state_t;
endpackage

// File: rtl/tile_line_ring.sv
// Four-row line ring: one write port, a rotating top pointer and a read port
// that returns one column of all four rows, ordered from the top row down.
module tile_line_ring
    import winograd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_wr_en,
    input  logic [1:0]                    i_wr_row,
    input  logic [$clog2(IMG_W)-1:0]      i_wr_col,
    input  logic [DATA_W-1:0]             i_wr_data,
    input  logic                          i_adv,
    input  logic [$clog2(IMG_W)-1:0]      i_rd_col,
    output logic [TILE-1:0][DATA_W-1:0]   o_rd
);
    logic [TILE-1:0][IMG_W-1:0][DATA_W-1:0] r_mem;
    logic [1:0]                             r_top;
    logic [1:0]                             w_wr_slot;

    // Write row is relative to top, so callers never see physical slots.
    assign w_wr_slot = r_top + i_wr_row;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem <= '0;
            r_top <= '0;
        end else begin
            if (i_wr_en) r_mem[w_wr_slot][i_wr_col] <= i_wr_data;
            if (i_adv)   r_top <= r_top + 2'd2;
        end
    end

    for (genvar j = 0; j < TILE; j++) begin : g_rd
        logic [1:0] w_slot;
        assign w_slot  = r_top + 2'(j);
        assign o_rd[j] = r_mem[w_slot][i_rd_col];
    end
endmodule

// File: rtl/winograd_tile_feeder.sv
// Sequences the Winograd engine inputs: weight store, band fill, and
// back-to-back 4-cycle stride-2 tiles with the kernel replayed per tile.
module winograd_tile_feeder
    import winograd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic [DATA_W-1:0] i_w_data,
    input  logic              i_w_valid,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic [DATA_W-1:0] o_r1_x,
    output logic [DATA_W-1:0] o_r2_x,
    output logic [DATA_W-1:0] o_r3_x,
    output logic [DATA_W-1:0] o_r4_x,
    output logic [DATA_W-1:0] o_r1_w,
    output logic [DATA_W-1:0] o_r2_w,
    output logic [DATA_W-1:0] o_r3_w,
    output logic              o_tile_valid,
    output logic              o_tile_first,
    output logic              o_frame_done
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int TW    = COL_W - 1;
    localparam int BW    = $clog2(IMG_H);
    localparam int NT    = IMG_W / OUT - 1;
    localparam int NB    = IMG_H / OUT - 1;
    localparam int NWT   = KERNEL * KERNEL;

    state_t                             r_state, w_state_nxt;
    logic [NWT-1:0][DATA_W-1:0]         r_wt;
    logic [3:0]                         r_w_cnt, w_widx;
    logic [1:0]                         r_fill_row;
    logic [COL_W-1:0]                   r_fill_col;
    logic [BW-1:0]                      r_band;
    logic [TW-1:0]                      r_tile;
    logic [1:0]                         r_k, w_k_nxt;
    logic [COL_W-1:0]                   w_base, w_rd_col;
    logic [TILE-1:0][DATA_W-1:0]        w_rd;
    logic [TILE-1:0][DATA_W-1:0]        r_x;
    logic [KERNEL-1:0][DATA_W-1:0]      r_w;
    logic                               r_in_ready, r_tile_valid, r_tile_first, r_frame_done;
    logic                               w_accept, w_fill_last, w_tile_last, w_band_last, w_adv;

    assign w_accept    = (r_state == ST_FILL) && i_in_valid;
    assign w_fill_last = w_accept && (r_fill_row == 2'd3) && (r_fill_col == COL_W'(IMG_W - 1));
    assign w_tile_last = (r_state == ST_EMIT) && (r_k == 2'd3) && (r_tile == TW'(NT - 1));
    assign w_band_last = (r_band == BW'(NB - 1));
    assign w_widx      = (r_w_cnt == 4'(NWT)) ? 4'd0 : r_w_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        case (r_state)
            ST_IDLE: if (i_frame_start && r_w_cnt == 4'(NWT)) w_state_nxt = ST_FILL;
            ST_FILL: if (w_fill_last) w_state_nxt = ST_EMIT;
            ST_EMIT: begin
                if (w_tile_last) begin
                    if (w_band_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_FILL;
                        w_adv       = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered, so the ring is read one cycle ahead of display.
    assign w_k_nxt  = (r_state == ST_EMIT) ? r_k + 2'd1 : 2'd0;
    assign w_base   = {r_tile, 1'b0};
    assign w_rd_col = (r_state != ST_EMIT) ? '0 :
                      (r_k == 2'd3)        ? w_base + COL_W'(2) :
                                             w_base + COL_W'(r_k) + COL_W'(1);

    // A refill band re-enters at row offset 2: after the top advance those
    // slots are exactly the two oldest rows being replaced.
    tile_line_ring #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_ring (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (w_accept),
        .i_wr_row  (r_fill_row),
        .i_wr_col  (r_fill_col),
        .i_wr_data (i_in_data),
        .i_adv     (w_adv),
        .i_rd_col  (w_rd_col),
        .o_rd      (w_rd)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wt         <= '0;
            r_w_cnt      <= '0;
            r_fill_row   <= '0;
            r_fill_col   <= '0;
            r_band       <= '0;
            r_tile       <= '0;
            r_k          <= '0;
            r_x          <= '0;
            r_w          <= '0;
            r_in_ready   <= 1'b0;
            r_tile_valid <= 1'b0;
            r_tile_first <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && i_w_valid) begin
                r_wt[w_widx] <= i_w_data;
                r_w_cnt      <= w_widx + 4'd1;
            end

            if (r_state == ST_IDLE && w_state_nxt == ST_FILL) begin
                r_fill_row <= 2'd0;
                r_fill_col <= '0;
                r_band     <= '0;
            end else if (w_adv) begin
                r_fill_row <= 2'd2;
                r_fill_col <= '0;
                r_band     <= r_band + BW'(1);
            end else if (w_accept) begin
                if (r_fill_col == COL_W'(IMG_W - 1)) begin
                    r_fill_col <= '0;
                    r_fill_row <= r_fill_row + 2'd1;
                end else begin
                    r_fill_col <= r_fill_col + COL_W'(1);
                end
            end

            if (r_state == ST_FILL) begin
                r_k    <= 2'd0;
                r_tile <= '0;
            end else if (r_state == ST_EMIT) begin
                r_k <= r_k + 2'd1;
                if (r_k == 2'd3) r_tile <= r_tile + TW'(1);
            end

            r_in_ready   <= (w_state_nxt == ST_FILL);
            r_frame_done <= (w_state_nxt == ST_DONE);
            if (w_state_nxt == ST_EMIT) begin
                r_tile_valid <= 1'b1;
                r_tile_first <= (w_k_nxt == 2'd0);
                r_x          <= w_rd;
                if (w_k_nxt != 2'd3) begin
                    for (int j = 0; j < KERNEL; j++)
                        r_w[j] <= r_wt[4'(w_k_nxt) * 4'd3 + 4'(j)];
                end
            end else begin
                r_tile_valid <= 1'b0;
                r_tile_first <= 1'b0;
                r_x          <= '0;
                r_w          <= '0;
            end
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_r1_x       = r_x[0];
    assign o_r2_x       = r_x[1];
    assign o_r3_x       = r_x[2];
    assign o_r4_x       = r_x[3];
    assign o_r1_w       = r_w[0];
    assign o_r2_w       = r_w[1];
    assign o_r3_w       = r_w[2];
    assign o_tile_valid = r_tile_valid;
    assign o_tile_first = r_tile_first;
    assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_winograd_tile_feeder.sv
// Directed/random bench for winograd_tile_feeder against an image-level model.
module tb_winograd_tile_feeder;
    localparam int DW = 32;
    localparam int IW = 8;
    localparam int IH = 8;
    localparam int NT = IW / 2 - 1;
    localparam int NB = IH / 2 - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic          w_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, tile_valid, tile_first, frame_done;
    logic [DW-1:0] r1_x, r2_x, r3_x, r4_x, r1_w, r2_w, r3_w;

    always #5 clk = ~clk;

    winograd_tile_feeder #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start),
        .i_w_data(w_data), .i_w_valid(w_valid),
        .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .o_r1_x(r1_x), .o_r2_x(r2_x), .o_r3_x(r3_x), .o_r4_x(r4_x),
        .o_r1_w(r1_w), .o_r2_w(r2_w), .o_r3_w(r3_w),
        .o_tile_valid(tile_valid), .o_tile_first(tile_first), .o_frame_done(frame_done)
    );

    typedef struct {
        logic [4*DW-1:0] x;
        logic [3*DW-1:0] w;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] pix [IH][IW];
    logic [DW-1:0] wt  [9];
    int            wcnt = 0;
    int            tile_firsts;
    int            accepted;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*DW-1:0] xs();
        return {r1_x, r2_x, r3_x, r4_x};
    endfunction

    function automatic logic [3*DW-1:0] ws();
        return {r1_w, r2_w, r3_w};
    endfunction

    // Model of the weight store: column-major index, restart after a full set.
    task automatic load_w(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = (wcnt == 9) ? 0 : wcnt;
            w_data  = rnd ? DW'($urandom) : DW'(idx);
            w_valid = 1'b1;
            wt[idx] = w_data;
            wcnt    = idx + 1;
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
    endtask

    task automatic make_pix(input bit rnd);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                pix[r][c] = rnd ? DW'($urandom) : DW'(10 * r + c);
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    // Band b covers rows 2b..2b+3; tile t cycle k shows column 2t+k and
    // kernel column min(k,2).
    task automatic push_band(input int b, inout exp_t q[$]);
        for (int t = 0; t < NT; t++)
            for (int k = 0; k < 4; k++) begin
                exp_t e;
                int   kc, c;
                kc = (k < 3) ? k : 2;
                c  = 2 * t + k;
                e.x = {pix[2*b][c], pix[2*b+1][c], pix[2*b+2][c], pix[2*b+3][c]};
                e.w = {wt[kc*3], wt[kc*3+1], wt[kc*3+2]};
                q.push_back(e);
            end
    endtask

    task automatic ignored_start(input string tag);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_rdy"}, 256'(in_ready), 256'(0));
            chk({tag, "_vld"}, 256'(tile_valid), 256'(0));
            @(posedge clk); #1;
        end
    endtask

    task automatic run_frame(input int gap_pct, input string tag);
        exp_t q[$];
        int   band = 0, cyc = 0, pos = 0;
        bit   rdy, exp_done = 0, done_seen = 0;
        tile_firsts = 0;
        accepted    = 0;
        pulse_start();
        chk({tag, "_rdy_start"}, 256'(in_ready), 256'(1));
        while (!done_seen && cyc < 3000) begin
            cyc++;
            in_valid = ($urandom_range(99) >= gap_pct) ? 1'b1 : 1'b0;
            in_data  = (accepted < IW * IH) ? pix[accepted / IW][accepted % IW] : DW'($urandom);
            w_valid  = 1'($urandom_range(1));
            w_data   = DW'($urandom);
            rdy      = in_ready;
            @(posedge clk);
            if (in_valid && rdy) begin
                accepted++;
                if (band < NB && accepted == IW * (2 * band + 4)) begin
                    push_band(band, q);
                    band++;
                end
            end
            #1;
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk({tag, "_vld"}, 256'(tile_valid), 256'(1));
                chk({tag, "_first"}, 256'(tile_first), 256'((pos % 4) == 0));
                chk({tag, "_x"}, 256'(xs()), 256'(e.x));
                chk({tag, "_w"}, 256'(ws()), 256'(e.w));
                chk({tag, "_rdy_emit"}, 256'(in_ready), 256'(0));
                chk({tag, "_done_emit"}, 256'(frame_done), 256'(0));
                if (tile_first) tile_firsts++;
                pos++;
                if (q.size() == 0 && band == NB) exp_done = 1;
            end else begin
                chk({tag, "_idle_vld"}, 256'(tile_valid), 256'(0));
                chk({tag, "_idle_first"}, 256'(tile_first), 256'(0));
                chk({tag, "_idle_x"}, 256'(xs()), 256'(0));
                chk({tag, "_idle_w"}, 256'(ws()), 256'(0));
                chk({tag, "_rdy"}, 256'(in_ready), 256'(accepted < IW * IH));
                chk({tag, "_done"}, 256'(frame_done), 256'(exp_done));
                if (exp_done) done_seen = 1;
            end
        end
        in_valid = 1'b0;
        w_valid  = 1'b0;
        chk({tag, "_finished"}, 256'(done_seen), 256'(1));
        chk({tag, "_firsts"}, 256'(tile_firsts), 256'(NT * NB));
        chk({tag, "_accepted"}, 256'(accepted), 256'(IW * IH));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 256'(frame_done), 256'(0));
        chk({tag, "_rdy_after"}, 256'(in_ready), 256'(0));
    endtask

    initial begin
        bit seen;
        int acc;
        #3;
        chk("reset_outs", 256'({in_ready, tile_valid, tile_first, frame_done}), 256'(0));
        chk("reset_x", 256'(xs()), 256'(0));
        chk("reset_w", 256'(ws()), 256'(0));
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        ignored_start("no_weights");
        load_w(9, 0);
        make_pix(0);
        run_frame(0, "f_ramp");
        run_frame(50, "f_gaps");

        load_w(9, 1);
        make_pix(1);
        run_frame(30, "f_rand");

        load_w(5, 1);
        ignored_start("partial_w");
        load_w(4, 1);
        run_frame(10, "f_partial");

        // Reset while tiles are being emitted.
        make_pix(1);
        pulse_start();
        acc  = 0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            bit rdy;
            in_valid = 1'b1;
            in_data  = pix[acc / IW][acc % IW];
            rdy      = in_ready;
            @(posedge clk);
            if (rdy) acc++;
            #1;
            seen = tile_valid;
        end
        in_valid = 1'b0;
        chk("rst_pre_vld", 256'(seen), 256'(1));
        @(posedge clk); #1;
        chk("rst_pre_vld2", 256'(tile_valid), 256'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_ctl", 256'({in_ready, tile_valid, tile_first, frame_done}), 256'(0));
        chk("rst_async_x", 256'(xs()), 256'(0));
        chk("rst_async_w", 256'(ws()), 256'(0));
        #2 rst_n = 1'b1;
        wcnt = 0;
        @(posedge clk); #1;
        ignored_start("post_rst");
        load_w(9, 1);
        run_frame(20, "f_post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
